// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the 5-stage MIPS pipeline.
// Used by the writeback/register-file block, the MEM/WB register and the
// forwarding unit so that all of them agree on datapath and address widths.
package mips_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

endpackage

// File: rtl/regfile_array.sv
// regfile_array: architectural register storage, no bypass.
//   clk, reset       : clock and synchronous active-high reset (clears all entries)
//   i_we, i_waddr,
//   i_wdata          : single write port, written on posedge
//   i_raddr1..3      : three asynchronous read addresses
//   o_rdata1..3      : raw stored contents at those addresses
// Entry 0 is never written by the parent, so it always holds zero.
module regfile_array
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    input  logic [ADDR_WIDTH-1:0] i_raddr3,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2,
    output logic [DATA_WIDTH-1:0] o_rdata3
);

    localparam int unsigned NumEntries = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [NumEntries];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumEntries; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
    assign o_rdata3 = r_mem[i_raddr3];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus architectural register file.
//   clk, reset                 : clock, synchronous active-high reset
//   ReadDataWB, ResultWB       : writeback candidates (load data / ALU result)
//   WriteRegWB, RegWriteWB     : destination register and write enable
//   MemtoRegWB                 : 1 selects load data, 0 selects ALU result
//   ReadReg1/2, ReadData1/2    : ID-stage read ports with same-cycle write bypass
//   DbgReg, DbgData            : debug read port, committed state only
//   WriteDataWB                : selected writeback value (to forwarding mux)
//   WbCount                    : committed write counter, wraps silently
//   LastWriteReg/LastWriteData : most recent committed write
module wb_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ReadDataWB,
    input  logic [DATA_WIDTH-1:0] ResultWB,
    input  logic [ADDR_WIDTH-1:0] WriteRegWB,
    input  logic                  RegWriteWB,
    input  logic                  MemtoRegWB,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] DbgReg,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic [DATA_WIDTH-1:0] WriteDataWB,
    output logic [CNT_WIDTH-1:0]  WbCount,
    output logic [ADDR_WIDTH-1:0] LastWriteReg,
    output logic [DATA_WIDTH-1:0] LastWriteData
);

    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_raw1;
    logic [DATA_WIDTH-1:0] w_raw2;
    logic [DATA_WIDTH-1:0] w_raw_dbg;

    logic [CNT_WIDTH-1:0]  r_wb_count;
    logic [ADDR_WIDTH-1:0] r_last_reg;
    logic [DATA_WIDTH-1:0] r_last_data;

    assign WriteDataWB = MemtoRegWB ? ReadDataWB : ResultWB;

    // Writes to $0 are dropped here so the array never stores into entry 0.
    assign w_commit = RegWriteWB && (WriteRegWB != ADDR_WIDTH'(REG_ZERO)) && !reset;

    regfile_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_commit),
        .i_waddr  (WriteRegWB),
        .i_wdata  (WriteDataWB),
        .i_raddr1 (ReadReg1),
        .i_raddr2 (ReadReg2),
        .i_raddr3 (DbgReg),
        .o_rdata1 (w_raw1),
        .o_rdata2 (w_raw2),
        .o_rdata3 (w_raw_dbg)
    );

    // Bypass: a commit to the addressed register shows up before the edge.
    // w_commit already excludes $0, so a $0 read never takes the bypass path.
    always_comb begin
        ReadData1 = w_raw1;
        ReadData2 = w_raw2;
        DbgData   = w_raw_dbg;
        if (reset) begin
            ReadData1 = '0;
            ReadData2 = '0;
            DbgData   = '0;
        end else begin
            if (w_commit && (WriteRegWB == ReadReg1)) begin
                ReadData1 = WriteDataWB;
            end
            if (w_commit && (WriteRegWB == ReadReg2)) begin
                ReadData2 = WriteDataWB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_count  <= '0;
            r_last_reg  <= '0;
            r_last_data <= '0;
        end else if (w_commit) begin
            r_wb_count  <= r_wb_count + CNT_WIDTH'(1);
            r_last_reg  <= WriteRegWB;
            r_last_data <= WriteDataWB;
        end
    end

    assign WbCount       = r_wb_count;
    assign LastWriteReg  = r_last_reg;
    assign LastWriteData = r_last_data;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ReadDataWB, ResultWB;
    logic [4:0]  WriteRegWB;
    logic        RegWriteWB, MemtoRegWB;
    logic [4:0]  ReadReg1, ReadReg2, DbgReg;

    logic [31:0] ReadData1, ReadData2, DbgData, WriteDataWB, WbCount, LastWriteData;
    logic [4:0]  LastWriteReg;

    // Second instance with a 4-bit counter, driven by the same stimulus.
    logic [31:0] s_rd1, s_rd2, s_dbg, s_wdata, s_last_data;
    logic [3:0]  s_cnt;
    logic [4:0]  s_last_reg;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .ReadDataWB    (ReadDataWB),
        .ResultWB      (ResultWB),
        .WriteRegWB    (WriteRegWB),
        .RegWriteWB    (RegWriteWB),
        .MemtoRegWB    (MemtoRegWB),
        .ReadReg1      (ReadReg1),
        .ReadReg2      (ReadReg2),
        .DbgReg        (DbgReg),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .DbgData       (DbgData),
        .WriteDataWB   (WriteDataWB),
        .WbCount       (WbCount),
        .LastWriteReg  (LastWriteReg),
        .LastWriteData (LastWriteData)
    );

    wb_regfile #(
        .CNT_WIDTH (4)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .ReadDataWB    (ReadDataWB),
        .ResultWB      (ResultWB),
        .WriteRegWB    (WriteRegWB),
        .RegWriteWB    (RegWriteWB),
        .MemtoRegWB    (MemtoRegWB),
        .ReadReg1      (ReadReg1),
        .ReadReg2      (ReadReg2),
        .DbgReg        (DbgReg),
        .ReadData1     (s_rd1),
        .ReadData2     (s_rd2),
        .DbgData       (s_dbg),
        .WriteDataWB   (s_wdata),
        .WbCount       (s_cnt),
        .LastWriteReg  (s_last_reg),
        .LastWriteData (s_last_data)
    );

    // Reference model: architectural state as plain arrays and integers.
    logic [31:0] m_regs [32];
    int unsigned m_cnt;
    logic [4:0]  m_last_reg;
    logic [31:0] m_last_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock of stimulus: check combinational outputs before the edge,
    // advance the model at the edge, then check registered/committed state.
    task automatic cycle(input logic rst, input logic [31:0] rdw, input logic [31:0] res,
                         input logic [4:0] wr, input logic we, input logic mtr,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        logic [31:0] wd;
        logic        commit;
        reset = rst; ReadDataWB = rdw; ResultWB = res; WriteRegWB = wr;
        RegWriteWB = we; MemtoRegWB = mtr; ReadReg1 = r1; ReadReg2 = r2; DbgReg = dbg;
        #1;
        wd     = mtr ? rdw : res;
        commit = we && (wr != 5'd0) && !rst;
        check("wdata", WriteDataWB, wd);
        check("rd1_pre", ReadData1, rst ? 32'd0 : ((commit && wr == r1) ? wd : m_regs[r1]));
        check("rd2_pre", ReadData2, rst ? 32'd0 : ((commit && wr == r2) ? wd : m_regs[r2]));
        check("rd1_small", s_rd1, ReadData1 === ReadData1 ? (rst ? 32'd0 :
              ((commit && wr == r1) ? wd : m_regs[r1])) : 32'd0);
        check("dbg_pre", DbgData, rst ? 32'd0 : m_regs[dbg]);
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_cnt       = 0;
            m_last_reg  = '0;
            m_last_data = '0;
        end else if (commit) begin
            m_regs[wr]  = wd;
            m_cnt       = m_cnt + 1;
            m_last_reg  = wr;
            m_last_data = wd;
        end
        #1;
        check("dbg_post", DbgData, rst ? 32'd0 : m_regs[dbg]);
        check("wbcount", WbCount, m_cnt);
        check("wbcount_small", {28'd0, s_cnt}, m_cnt % 16);
        check("last_reg", {27'd0, LastWriteReg}, {27'd0, m_last_reg});
        check("last_data", LastWriteData, m_last_data);
        check("last_reg_small", {27'd0, s_last_reg}, {27'd0, m_last_reg});
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_cnt = 0; m_last_reg = '0; m_last_data = '0;

        // Reset, then sweep the debug port over every register.
        cycle(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3);
        cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            DbgReg = 5'(i);
            #1;
            check("reset_dbg", DbgData, 32'd0);
        end

        // ALU result to $8 with same-cycle bypass on port 1.
        cycle(1'b0, 32'h0, 32'h1234ABCD, 5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8);
        check("t2_dbg8", DbgData, 32'h1234ABCD);
        check("t2_cnt", WbCount, 32'd1);
        check("t2_last", {27'd0, LastWriteReg}, 32'd8);

        // Load data selected, both ports on $9.
        cycle(1'b0, 32'hDEADBEEF, 32'h5, 5'd9, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9);
        check("t3_dbg9", DbgData, 32'hDEADBEEF);

        // Write to $0 is discarded.
        cycle(1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0);
        check("t4_cnt", WbCount, 32'd2);

        // Reset wins over commit, then the first cycle out of reset commits.
        cycle(1'b1, 32'h0, 32'hA5A5A5A5, 5'd10, 1'b1, 1'b0, 5'd10, 5'd8, 5'd10);
        check("t5_cnt_rst", WbCount, 32'd0);
        cycle(1'b0, 32'h0, 32'hA5A5A5A5, 5'd10, 1'b1, 1'b0, 5'd10, 5'd8, 5'd10);
        check("t5_dbg10", DbgData, 32'hA5A5A5A5);
        check("t5_cnt", WbCount, 32'd1);

        // Fifteen more commits: the 4-bit counter wraps 15 -> 0.
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 32'h0, 32'h100 + 32'(i), 5'(1 + (i % 3)), 1'b1, 1'b0,
                  5'd10, 5'(1 + (i % 3)), 5'd10);
        end
        check("wrap_small", {28'd0, s_cnt}, 32'd0);
        check("wrap_full", WbCount, 32'd16);
        check("wrap_keep10", DbgData, 32'hA5A5A5A5);

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(31) == 0), $urandom, $urandom, 5'($urandom_range(31)),
                  ($urandom_range(3) != 0), 1'($urandom_range(1)),
                  5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage MIPS pipeline. It sits downstream of the MEM/WB pipeline register and consumes its WB-side outputs. It selects the writeback value (load data or ALU result), commits it to a 32×32 register file, and serves the ID stage's two read ports with same-cycle write bypass. It also exposes a debug read port and writeback statistics for the testbench and board display.

## Interface
Parameters:
- DATA_WIDTH, 32, register and datapath width
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)
- CNT_WIDTH, 32, width of the writeback event counter

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clock clk
- ReadDataWB  in  DATA_WIDTH  load data from MEM/WB
- ResultWB  in  DATA_WIDTH  ALU result from MEM/WB
- WriteRegWB  in  ADDR_WIDTH  destination register
- RegWriteWB  in  1  write enable from MEM/WB
- MemtoRegWB  in  1  1 selects ReadDataWB, 0 selects ResultWB
- ReadReg1  in  ADDR_WIDTH  ID-stage rs address
- ReadReg2  in  ADDR_WIDTH  ID-stage rt address
- DbgReg  in  ADDR_WIDTH  debug read address
- ReadData1  out  DATA_WIDTH  rs data, combinational
- ReadData2  out  DATA_WIDTH  rt data, combinational
- DbgData  out  DATA_WIDTH  debug data, combinational, no bypass
- WriteDataWB  out  DATA_WIDTH  selected writeback value, combinational (feeds the forwarding mux)
- WbCount  out  CNT_WIDTH  number of committed register writes, registered
- LastWriteReg  out  ADDR_WIDTH  address of the most recent committed write, registered
- LastWriteData  out  DATA_WIDTH  data of the most recent committed write, registered

## Operation
- WriteDataWB = MemtoRegWB ? ReadDataWB : ResultWB. This is independent of RegWriteWB.
- Effective write ("commit") = RegWriteWB && WriteRegWB != 0 && !reset.
- On commit at posedge: regs[WriteRegWB] <= WriteDataWB; WbCount increments by 1; LastWriteReg/LastWriteData are updated.
- Writes to $0 are discarded. They are not counted and do not update LastWrite*.
- $0 always reads 0 on every port.
- Read ports 1 and 2 use bypass. If commit would occur this cycle and WriteRegWB == ReadRegN (and ReadRegN != 0), ReadDataN = WriteDataWB. Otherwise ReadDataN = regs[ReadRegN]. This replaces the textbook write-first-half/read-second-half scheme.
- DbgData returns regs[DbgReg] only, with no bypass. It shows the committed state.
- While reset is high, ReadData1, ReadData2 and DbgData are forced to 0.
- WbCount wraps from 2^CNT_WIDTH−1 to 0 with no saturation and no flag.

## Timing
- Reset (sync): on a posedge with reset=1, all 32 registers, WbCount, LastWriteReg and LastWriteData become 0. Reset wins over a simultaneous commit.
- Reset deasserted mid-stream: the first posedge with reset=0 may commit normally.
- Write latency: a commit at edge N is visible on DbgData after edge N. It is visible on ReadData1/2 during the cycle before edge N, via bypass.
- Read ports have zero-cycle combinational latency with no handshake. The pipeline guarantees inputs are stable before the edge.
- When both read ports address the same register, both return the identical value, including under bypass.
- Back-to-back commits to the same register: the last one wins, and each commit is counted.
- No state machine is required. State consists of the register array, the counter and the last-write registers.

## Structure
- Shared package `mips_pkg` holds DATA_WIDTH, ADDR_WIDTH, NUM_REGS=32 and REG_ZERO=5'd0. The MEM/WB register and the forwarding unit also use these.
- One sub-module, `regfile_array`, contains the storage, the synchronous reset clear, one write port and three unbypassed async read ports.
- The top level holds the writeback mux, the commit logic, the bypass muxes and the statistics registers.

## Test plan
- Reset, then read all 32 registers via DbgReg → DbgData=0, WbCount=0, LastWriteReg=0.
- ResultWB=0x1234ABCD, MemtoRegWB=0, WriteRegWB=8, RegWriteWB=1, ReadReg1=8 in the same cycle → ReadData1=0x1234ABCD before the edge. After the edge: DbgData(8)=0x1234ABCD, WbCount=1, LastWriteReg=8.
- MemtoRegWB=1, ReadDataWB=0xDEADBEEF, ResultWB=0x5, WriteRegWB=9, RegWriteWB=1 → WriteDataWB=0xDEADBEEF and regs[9]=0xDEADBEEF.
- Write 0xFFFFFFFF to $0 with RegWriteWB=1 and ReadReg2=0 → ReadData2=0, $0 stays 0, WbCount unchanged.
- Commit to $10 with reset=1 in the same cycle → regs[10]=0, WbCount=0. Deassert reset and repeat the commit → regs[10] is written and WbCount=1.
- Simulate with CNT_WIDTH=4 and perform 16 commits → WbCount=15→0, and all other state is unaffected.
